muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Extends the single-cycle ALU with multi-cycle MULT/MULTU/DIV/DIVU and a valid/ready handshake.
- Sits beside the ALU in the execute stage; the controller issues ops and stalls on in_ready.
- HI/LO are also written directly by MTHI/MTLO and read by MFHI/MFLO.

Parameters:
- WIDTH, 32, operand, HI and LO width; must be at least 2. Sets iteration count.
- DIV0_FLAG, 1, 1 = drive the div_by_zero status output; 0 = tie it to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  op request.
- in_ready  out  1  unit can accept an op this cycle.
- op  in  2  0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- opa  in  WIDTH  multiplicand / dividend (rs).
- opb  in  WIDTH  multiplier / divisor (rt).
- flush  in  1  cancel the in-flight op.
- out_valid  out  1  result in HI/LO is ready.
- out_ready  in  1  consumer takes the result.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_by_zero  out  1  last completed DIV/DIVU had divisor 0.

Behaviour:
- Reset values: state IDLE; hi = 0, lo = 0, out_valid = 0, div_by_zero = 0; in_ready = 1 in the first cycle after reset.
- Reset has priority over all other inputs, including mid-operation; any in-flight op is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept.
  - CALC runs a down-counter from WIDTH-1 to 0, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE on out_ready, or -> CALC if a new op is accepted in the same cycle.
- Accept condition: in_valid & in_ready.
  - in_ready = (state == IDLE) | (state == DONE & out_ready).
  - This gives back-to-back issue with no bubble.
- Latency: out_valid rises after WIDTH+1 rising edges following the accepting edge (33 for WIDTH = 32).
  - out_valid = (state == DONE) and holds until out_ready.
  - hi/lo are stable while out_valid = 1.
- Operand capture on accept: for signed ops, latch |opa|, |opb| and the result signs. The absolute value of MIN is representable as an unsigned WIDTH-bit value.
- CALC datapath, one bit per cycle:
  - Multiply: shift-add into a 2*WIDTH-bit accumulator.
  - Divide: restoring division, WIDTH+1-bit partial remainder.
- FIX: apply sign correction and the special cases, then write HI/LO.
  - MULT/MULTU: {hi, lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Divisor 0: lo = all ones, hi = opa, div_by_zero = 1. The full WIDTH cycles are still taken.
  - DIV of MIN by -1: lo = MIN, hi = 0, no flag.
  - div_by_zero is updated only at the FIX of a DIV/DIVU; it holds otherwise.
- hi/lo change only at FIX, on MTHI/MTLO, or on reset.
- MTHI/MTLO:
  - Honoured in IDLE and DONE.
  - Ignored in CALC and FIX; the controller must not issue them while busy.
  - In DONE, a write updates the register; out_valid is unaffected.
- flush:
  - In CALC or FIX: next state IDLE, HI/LO and div_by_zero unchanged, no out_valid.
  - In DONE: drop out_valid and go to IDLE; HI/LO keep the completed result.
  - In IDLE: no effect, and the accept is blocked that cycle.
  - An accept in the same cycle as flush is ignored.
- out_ready while out_valid = 0: ignored.

Decomposition:
- muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum IDLE, CALC, FIX, DONE;
  - the counter width function clog2(WIDTH).
- Sub-module muldiv_signfix: combinational absolute value and conditional negate, WIDTH-parametrised.
  - Instantiated twice for operand capture.
  - Instantiated once, at 2*WIDTH width, for result correction.
- The FSM, counter and datapath stay in muldiv_unit.

Test Plan:
- MULT, opa = 0xFFFFFFFD (-3), opb = 7 -> after 33 edges out_valid = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIVU 100 / 7 -> lo = 0x0000000E, hi = 0x00000002; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 5 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000005, div_by_zero = 1; next DIV 8 / 2 -> div_by_zero = 0, lo = 4, hi = 0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
- Back-pressure and back-to-back:
  - Hold out_ready = 0 for 10 cycles -> out_valid, hi and lo stay stable and in_ready = 0.
  - Then assert out_ready with in_valid = 1 and a new op -> accepted the same cycle, next result 33 edges later.
- MTLO 0x1234 then flush at CALC cycle 5 -> in_ready = 1 the next cycle, lo = 0x1234, out_valid never asserted; rst at CALC cycle 10 -> hi = lo = 0 and IDLE the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sizing helper for the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result handshake and HI/LO access bundle of the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output in_valid, op, opa, opb, flush, out_ready, hi_we, lo_we, wdata,
        input  in_ready, out_valid, hi, lo, div_by_zero
    );
    modport slave (
        input  in_valid, op, opa, opb, flush, out_ready, hi_we, lo_we, wdata,
        output in_ready, out_valid, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate, used for absolute value and sign correction
module muldiv_signfix #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = neg_i ? -a_i : a_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide with HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit DIV0_FLAG = 1'b1
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW = clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d, opa_q, opa_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, res;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic               sgn, accept, is_mul, ok;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_fix;
    logic [WIDTH:0]     msum, shifted, diff;

    assign sgn     = bus.op == OP_MULT || bus.op == OP_DIV;
    assign is_mul  = op_q != OP_DIV && op_q != OP_DIVU;
    assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign ok      = shifted >= {1'b0, b_q};
    assign diff    = shifted - {1'b0, b_q};
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.a_i(bus.opa), .neg_i(sgn & bus.opa[WIDTH-1]), .y_o(abs_a));
    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.a_i(bus.opb), .neg_i(sgn & bus.opb[WIDTH-1]), .y_o(abs_b));
    muldiv_signfix #(.WIDTH(2*WIDTH)) u_res (
        .a_i(is_mul ? acc_q : {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]}),
        .neg_i(neg_res_q),
        .y_o(res)
    );

    assign bus.in_ready    = state_q == IDLE || (state_q == DONE && bus.out_ready);
    assign accept          = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.out_valid   = state_q == DONE;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = DIV0_FLAG & dz_q;

    // next state, operand capture, one iteration step per CALC cycle, result write-back and MTHI/MTLO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        b_d       = b_q;
        opa_d     = opa_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE:    state_d = accept ? CALC : IDLE;
            CALC:    state_d = bus.flush ? IDLE : cnt_q == '0 ? FIX : CALC;
            FIX:     state_d = bus.flush ? IDLE : DONE;
            default: state_d = bus.flush ? IDLE : accept ? CALC : bus.out_ready ? IDLE : DONE;
        endcase
        if (accept) begin
            cnt_d     = CW'(WIDTH - 1);
            op_d      = bus.op;
            b_d       = abs_b;
            opa_d     = bus.opa;
            rem_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, abs_a};
            neg_res_d = sgn & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            neg_rem_d = sgn & bus.opa[WIDTH-1];
        end
        if (state_q == CALC) begin
            cnt_d = cnt_q - 1'b1;
            acc_d = is_mul ? {acc_q[0] ? msum : {1'b0, acc_q[2*WIDTH-1:WIDTH]}, acc_q[WIDTH-1:1]}
                           : {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ok};
            rem_d = is_mul ? rem_q : WIDTH'(ok ? diff : shifted);
        end
        if (state_q == FIX && !bus.flush) begin
            if (is_mul) begin
                {hi_d, lo_d} = res;
            end else if (b_q == '0) begin
                lo_d = '1;
                hi_d = opa_q;
                dz_d = 1'b1;
            end else begin
                lo_d = res[WIDTH-1:0];
                hi_d = rem_fix;
                dz_d = 1'b0;
            end
        end
        if (state_q == IDLE || state_q == DONE) begin
            hi_d = bus.hi_we ? bus.wdata : hi_d;
            lo_d = bus.lo_we ? bus.wdata : lo_d;
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            b_q       <= '0;
            opa_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            b_q       <= b_d;
            opa_q     <= opa_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed check of muldiv_unit against a transaction-level model
module tb_muldiv_unit;
    import muldiv_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int          busy = 0;
    logic        m_ov = 1'b0;
    logic        m_dz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] p_hi, p_lo;
    logic        p_dz, p_div;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W), .DIV0_FLAG(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l,
                                 output logic d, output logic is_div);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] p;
        d = 1'b0;
        is_div = o == OP_DIV || o == OP_DIVU;
        if (o == OP_MULT) p = 64'(sa * sb);
        else if (o == OP_MULTU) p = {32'b0, a} * {32'b0, b};
        else if (b == 0) begin p = {a, 32'hFFFF_FFFF}; d = 1'b1; end
        else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else if (o == OP_DIV) p = {32'(sa % sb), 32'(sa / sb)};
        else p = {a % b, a / b};
        {h, l} = p;
    endfunction

    initial begin
        logic rdy, acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                busy = 0; m_ov = 1'b0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
            end else begin
                rdy = busy == 0 && (!m_ov || bus.out_ready);
                acc = bus.in_valid && rdy && !bus.flush;
                if (busy == 0) begin
                    if (bus.hi_we) m_hi = bus.wdata;
                    if (bus.lo_we) m_lo = bus.wdata;
                end
                if (busy > 0) begin
                    if (bus.flush) busy = 0;
                    else begin
                        busy--;
                        if (busy == 0) begin
                            m_hi = p_hi; m_lo = p_lo; m_ov = 1'b1;
                            if (p_div) m_dz = p_dz;
                        end
                    end
                end else if (m_ov && (bus.flush || bus.out_ready)) m_ov = 1'b0;
                if (acc) begin
                    calc(bus.op, bus.opa, bus.opb, p_hi, p_lo, p_dz, p_div);
                    busy = W + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", bus.out_valid, m_ov);
                chk("in_ready", bus.in_ready, busy == 0 && (!m_ov || bus.out_ready));
                chk("hi", bus.hi, m_hi);
                chk("lo", bus.lo, m_lo);
                chk("div_by_zero", bus.div_by_zero, m_dz);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        chk("issue_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        issue(o, a, b);
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 64'(W + 1));
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        int r = $urandom_range(0, 7);
        return r == 0 ? 32'h0 : r == 1 ? 32'h8000_0000 : r == 2 ? 32'hFFFF_FFFF : r == 3 ? 32'h1 : $urandom;
    endfunction

    initial begin
        logic [W-1:0] h0, l0;
        bus.in_valid = 0; bus.op = 0; bus.opa = 0; bus.opb = 0; bus.flush = 0;
        bus.out_ready = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("rst_dz", bus.div_by_zero, 1'b0);
        @(posedge clk); #1;

        run(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_pin", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB); pop();
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_pin", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001); pop();
        run(OP_DIVU, 32'd100, 32'd7);
        chk("divu_pin", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E); pop();
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_pin", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD); pop();
        run(OP_DIV, 32'd5, 32'd0);
        chk("div0_pin", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        chk("div0_flag", bus.div_by_zero, 1'b1); pop();
        run(OP_DIV, 32'd8, 32'd2);
        chk("div82_pin", {bus.hi, bus.lo}, 64'h0000_0000_0000_0004);
        chk("div82_flag", bus.div_by_zero, 1'b0); pop();
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("minneg1_pin", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        chk("minneg1_flag", bus.div_by_zero, 1'b0);

        h0 = bus.hi; l0 = bus.lo;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_stable", {bus.hi, bus.lo}, {h0, l0});
        end
        bus.out_ready = 1'b1;
        run(OP_MULTU, 32'd1000, 32'd3000);
        bus.out_ready = 1'b0;
        chk("b2b_pin", {bus.hi, bus.lo}, 64'd3000000);

        bus.hi_we = 1'b1; bus.wdata = 32'hCAFE;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("mthi_done", {bus.out_valid, bus.hi}, {1'b1, 32'hCAFE});
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_done", {bus.out_valid, bus.hi, bus.lo}, {1'b0, 32'hCAFE, 32'd3000000});

        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = OP_MULTU; bus.opa = 5; bus.opb = 5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_idle", bus.in_ready, 1'b1);

        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        issue(OP_MULTU, 32'd77, 32'd99);
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_calc_ready", bus.in_ready, 1'b1);
        chk("flush_calc_lo", bus.lo, 32'h1234);
        repeat (40) begin
            @(posedge clk); #1;
            chk("flush_no_valid", bus.out_valid, 1'b0);
        end

        bus.hi_we = 1'b1; bus.wdata = 32'h5555;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("rst_mid_state", {bus.in_ready, bus.out_valid}, 2'b10);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            run(2'($urandom_range(0, 3)), pick(), pick());
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 3) == 0) begin
                bus.lo_we = 1'b1; bus.wdata = $urandom;
                @(posedge clk); #1;
                bus.lo_we = 1'b0;
            end
            pop();
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
